kgp_control_fsm: RTL and testbench

- Multi-cycle main controller for the KGP-RISC core.
- Consumes the decoded opcode/fcode fields and the latched ALU flags; sequences fetch, decode, execute, memory and writeback.
- Drives the load enables for PC, IR, register file and flag register, plus ALU function select and data-memory strobes.
- Sits between the instruction decoder and the datapath muxes; owns the instruction and data memory request/acknowledge handshakes.

---
 rtl/kgp_ctrl_pkg.sv | 49 ++++
 rtl/kgp_control_fsm_if.sv | 19 +
 rtl/kgp_branch_eval.sv | 28 ++
 rtl/kgp_control_fsm.sv | 223 ++++++++++++++++++++++
 tb/tb_kgp_control_fsm.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC main controller:
// opcodes, fcodes, states, ALU and mux selects.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_IMM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [3:0] FC_ADDI  = 4'b0000;
  localparam logic [3:0] FC_COMPI = 4'b0001;
  localparam logic [3:0] FC_LW    = 4'b0010;
  localparam logic [3:0] FC_SW    = 4'b0011;
  localparam logic [3:0] FC_HALT  = 4'b1111;

  localparam logic [3:0] FC_B    = 4'b0000;
  localparam logic [3:0] FC_BR   = 4'b0001;
  localparam logic [3:0] FC_BLTZ = 4'b0010;
  localparam logic [3:0] FC_BZ   = 4'b0011;
  localparam logic [3:0] FC_BNZ  = 4'b0100;
  localparam logic [3:0] FC_BL   = 4'b0101;
  localparam logic [3:0] FC_BCY  = 4'b0110;
  localparam logic [3:0] FC_BNCY = 4'b0111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  localparam logic [1:0] PC_IMM = 2'b00;
  localparam logic [1:0] PC_REG = 2'b01;
  localparam logic [1:0] PC_ABS = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  function automatic logic is_wait(state_t s);
    return (s == S_FETCH) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/kgp_control_fsm_if.sv
// Instruction/data memory request-acknowledge bundle
// between the controller (master) and the memories.
interface kgp_control_fsm_if;
  logic imem_req;
  logic imem_ack;
  logic dmem_re;
  logic dmem_we;
  logic dmem_ack;

  modport master (
    output imem_req, dmem_re, dmem_we,
    input  imem_ack, dmem_ack
  );

  modport slave (
    input  imem_req, dmem_re, dmem_we,
    output imem_ack, dmem_ack
  );
endinterface

// File: rtl/kgp_branch_eval.sv
// Branch condition evaluator: fcode + latched flags
// -> taken / legal.
module kgp_branch_eval
  import kgp_ctrl_pkg::*;
(
  input  logic [3:0] fcode,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_s,
  output logic       taken,
  output logic       legal
);

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    unique case (fcode)
      FC_B, FC_BR, FC_BL: taken = 1'b1;
      FC_BLTZ:            taken = flag_s;
      FC_BZ:              taken = flag_z;
      FC_BNZ:             taken = ~flag_z;
      FC_BCY:             taken = flag_c;
      FC_BNCY:            taken = ~flag_c;
      default:            legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/kgp_control_fsm.sv
// KGP-RISC multi-cycle main controller.
// KGP_CTRL_PERF_EN adds cyc_cnt/ret_cnt counters.
module kgp_control_fsm
  import kgp_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] opcode,
  input  logic [3:0] fcode,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       flag_s,
  kgp_control_fsm_if.master mem,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] wb_src,
  output logic [3:0] alu_fn,
  output logic       alu_b_imm,
  output logic       flags_we,
  output logic       halted,
  output logic       fault,
`ifdef KGP_CTRL_PERF_EN
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
`endif
  output logic [2:0] state_dbg
);

  if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255 || CNT_W < 1)
  begin : g_bad_cfg
    $error("kgp_control_fsm: illegal parameters");
  end

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] op_q, op_d;
  logic [3:0] fc_q, fc_d;
  logic       br_taken, br_legal;
  logic       to_hit;
  logic       imem_req_o, dmem_re_o, dmem_we_o;

  kgp_branch_eval u_br (
    .fcode  (fc_q),
    .flag_z (flag_z),
    .flag_c (flag_c),
    .flag_s (flag_s),
    .taken  (br_taken),
    .legal  (br_legal)
  );

  assign to_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      fc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fc_q    <= fc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fc_d    = fc_q;
    unique case (state_q)
      S_FETCH: begin
        if (mem.imem_ack)  state_d = S_DECODE;
        else if (to_hit)   state_d = S_FAULT;
      end
      S_DECODE: begin
        op_d = opcode;
        fc_d = fcode;
        if (opcode != OP_SYS)      state_d = S_EXEC;
        else if (fcode == FC_HALT) state_d = S_HALT;
        else                       state_d = S_FAULT;
      end
      S_EXEC: begin
        unique case (op_q)
          OP_ALU: state_d = S_WB;
          OP_IMM: begin
            unique case (fc_q)
              FC_ADDI, FC_COMPI: state_d = S_WB;
              FC_LW, FC_SW:      state_d = S_MEM;
              default:           state_d = S_FAULT;
            endcase
          end
          OP_BR:
            state_d = br_legal ? S_FETCH : S_FAULT;
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        // ack beats timeout when both land together
        if (mem.dmem_ack)
          state_d = (fc_q == FC_LW) ? S_WB : S_FETCH;
        else if (to_hit)
          state_d = S_FAULT;
      end
      S_WB:            state_d = S_FETCH;
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_FAULT;
    endcase
    if (state_d != state_q || !is_wait(state_q))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    imem_req_o = 1'b0;
    dmem_re_o  = 1'b0;
    dmem_we_o  = 1'b0;
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_src     = PC_IMM;
    reg_we     = 1'b0;
    wb_src     = WB_ALU;
    alu_fn     = ALU_ADD;
    alu_b_imm  = 1'b0;
    flags_we   = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state_q == S_FETCH: begin
          imem_req_o = 1'b1;
          ir_load    = mem.imem_ack;
          pc_inc     = mem.imem_ack;
        end
        state_q == S_EXEC: begin
          unique case (op_q)
            OP_ALU: begin
              alu_fn   = fc_q;
              flags_we = 1'b1;
            end
            OP_IMM: begin
              if (fc_q == FC_ADDI || fc_q == FC_COMPI) begin
                alu_fn    = fc_q;
                alu_b_imm = 1'b1;
                flags_we  = 1'b1;
              end else if (fc_q == FC_LW || fc_q == FC_SW) begin
                alu_fn    = ALU_ADD;
                alu_b_imm = 1'b1;
              end
            end
            OP_BR: begin
              if (br_legal) begin
                pc_load = br_taken;
                if (fc_q == FC_B)       pc_src = PC_ABS;
                else if (fc_q == FC_BR) pc_src = PC_REG;
                if (fc_q == FC_BL) begin
                  reg_we = 1'b1;
                  wb_src = WB_LINK;
                end
              end
            end
            default: ;
          endcase
        end
        state_q == S_MEM: begin
          dmem_re_o = (fc_q == FC_LW);
          dmem_we_o = (fc_q == FC_SW);
        end
        state_q == S_WB: begin
          reg_we = 1'b1;
          if (op_q == OP_IMM && fc_q == FC_LW) wb_src = WB_MEM;
        end
        state_q == S_HALT:  halted = 1'b1;
        state_q == S_FAULT: fault  = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.imem_req = imem_req_o;
  assign mem.dmem_re  = dmem_re_o;
  assign mem.dmem_we  = dmem_we_o;
  assign state_dbg    = state_q;

`ifdef KGP_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d;

  always_comb begin
    cyc_d = cyc_q;
    ret_d = ret_q;
    if (state_q != S_HALT && state_q != S_FAULT)
      cyc_d = cyc_q + CNT_W'(1);
    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM ||
         state_q == S_WB))
      ret_d = ret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Directed scoreboard bench for kgp_control_fsm.
// Expected output vectors are queued per cycle and popped at negedge.
module tb_kgp_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] opcode = '0;
  logic [3:0] fcode = '0;
  logic       flag_z = 1'b0;
  logic       flag_c = 1'b0;
  logic       flag_s = 1'b0;
  logic       ir_load, pc_inc, pc_load, reg_we;
  logic [1:0] pc_src, wb_src;
  logic [3:0] alu_fn;
  logic       alu_b_imm, flags_we, halted, fault;
  logic [2:0] state_dbg;
`ifdef KGP_CTRL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
  logic [31:0] exp_cyc = '0;
  logic [31:0] exp_ret = '0;
  logic [2:0]  prev_st = '0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  kgp_control_fsm_if bus ();

  kgp_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .fcode     (fcode),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_s    (flag_s),
    .mem       (bus),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_src    (pc_src),
    .reg_we    (reg_we),
    .wb_src    (wb_src),
    .alu_fn    (alu_fn),
    .alu_b_imm (alu_b_imm),
    .flags_we  (flags_we),
    .halted    (halted),
    .fault     (fault),
`ifdef KGP_CTRL_PERF_EN
    .cyc_cnt   (cyc_cnt),
    .ret_cnt   (ret_cnt),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [21:0] IREQ  = 22'd1 << 21;
  localparam logic [21:0] IRLD  = 22'd1 << 20;
  localparam logic [21:0] PCINC = 22'd1 << 19;
  localparam logic [21:0] PCLD  = 22'd1 << 18;
  localparam logic [21:0] REGWE = 22'd1 << 15;
  localparam logic [21:0] BIMM  = 22'd1 << 8;
  localparam logic [21:0] FWE   = 22'd1 << 7;
  localparam logic [21:0] DRE   = 22'd1 << 6;
  localparam logic [21:0] DWE   = 22'd1 << 5;
  localparam logic [21:0] HLT   = 22'd1 << 4;
  localparam logic [21:0] FLT   = 22'd1 << 3;

  function automatic logic [21:0] st(input int s);
    return 22'(s & 7);
  endfunction
  function automatic logic [21:0] pcs(input int x);
    return 22'(x & 3) << 16;
  endfunction
  function automatic logic [21:0] wbs(input int x);
    return 22'(x & 3) << 13;
  endfunction
  function automatic logic [21:0] afn(input int x);
    return 22'(x & 15) << 9;
  endfunction

  logic [21:0] obs;
  assign obs = {bus.imem_req, ir_load, pc_inc, pc_load,
                pc_src, reg_we, wb_src, alu_fn, alu_b_imm,
                flags_we, bus.dmem_re, bus.dmem_we,
                halted, fault, state_dbg};

  typedef struct {
    string       tag;
    logic [21:0] v;
  } exp_t;
  exp_t sb[$];

  task automatic check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty got=%h want=entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.v) else begin
      n_bad++;
      $error("FAIL %s got=%h want=%h", e.tag, obs, e.v);
    end
`ifdef KGP_CTRL_PERF_EN
    if (!rst && e.v[2:0] == 3'd0 &&
        prev_st inside {3'd2, 3'd3, 3'd4})
      exp_ret++;
    n_cmp++;
    assert (cyc_cnt === exp_cyc) else begin
      n_bad++;
      $error("FAIL %s_cyc got=%0d want=%0d",
             e.tag, cyc_cnt, exp_cyc);
    end
    n_cmp++;
    assert (ret_cnt === exp_ret) else begin
      n_bad++;
      $error("FAIL %s_ret got=%0d want=%0d",
             e.tag, ret_cnt, exp_ret);
    end
`endif
  endtask

  task automatic step(input string tag,
                      input logic [21:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(negedge clk);
    check();
`ifdef KGP_CTRL_PERF_EN
    if (rst) begin
      exp_cyc = '0;
      exp_ret = '0;
      prev_st = '0;
    end else begin
      if (v[2:0] != 3'd5 && v[2:0] != 3'd6)
        exp_cyc++;
      prev_st = v[2:0];
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic tick_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
`ifdef KGP_CTRL_PERF_EN
    exp_cyc = '0;
    exp_ret = '0;
    prev_st = '0;
`endif
  endtask

  task automatic fetch_dec(input logic [1:0] op,
                           input logic [3:0] fc);
    opcode = op;
    fcode  = fc;
    bus.imem_ack = 1'b1;
    step("fetch", IREQ | IRLD | PCINC | st(0));
    bus.imem_ack = 1'b0;
    step("decode", st(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    tick_rst();
    step("rst_idle", st(0));
    rst = 1'b0;

    fetch_dec(2'b00, 4'b0000);
    step("alu0_ex", afn(0) | FWE | st(2));
    step("alu0_wb", REGWE | wbs(0) | st(4));
    fetch_dec(2'b00, 4'b0110);
    step("alu6_ex", afn(6) | FWE | st(2));
    step("alu6_wb", REGWE | wbs(0) | st(4));

    fetch_dec(2'b01, 4'b0010);
    step("lw_ex", afn(0) | BIMM | st(2));
    repeat (3) step("lw_wait", DRE | st(3));
    bus.dmem_ack = 1'b1;
    step("lw_ack", DRE | st(3));
    bus.dmem_ack = 1'b0;
    step("lw_wb", REGWE | wbs(1) | st(4));

    fetch_dec(2'b01, 4'b0011);
    step("sw_ex", afn(0) | BIMM | st(2));
    bus.dmem_ack = 1'b1;
    step("sw_ack", DWE | st(3));
    bus.dmem_ack = 1'b0;

    fetch_dec(2'b01, 4'b0000);
    step("addi_ex", afn(0) | BIMM | FWE | st(2));
    step("addi_wb", REGWE | wbs(0) | st(4));

    flag_z = 1'b1;
    fetch_dec(2'b10, 4'b0011);
    step("bz_taken", PCLD | pcs(0) | st(2));
    flag_z = 1'b0;
    fetch_dec(2'b10, 4'b0011);
    step("bz_not", st(2));
    fetch_dec(2'b10, 4'b0101);
    step("bl", PCLD | pcs(0) | REGWE | wbs(2) | st(2));
    fetch_dec(2'b10, 4'b0000);
    step("b_abs", PCLD | pcs(2) | st(2));
    fetch_dec(2'b10, 4'b0001);
    step("br_reg", PCLD | pcs(1) | st(2));
    flag_s = 1'b1;
    fetch_dec(2'b10, 4'b0010);
    step("bltz_taken", PCLD | pcs(0) | st(2));
    flag_s = 1'b0;
    fetch_dec(2'b10, 4'b0111);
    step("bncy_taken", PCLD | pcs(0) | st(2));
    fetch_dec(2'b10, 4'b0110);
    step("bcy_not", st(2));

    fetch_dec(2'b01, 4'b0011);
    step("sw2_ex", afn(0) | BIMM | st(2));
    step("sw2_wait", DWE | st(3));
    tick_rst();
    step("rst_mid_mem", st(0));
    rst = 1'b0;

    for (int i = 0; i < 15; i++)
      step("fetch_wait", IREQ | st(0));
    opcode = 2'b01;
    fcode  = 4'b0111;
    bus.imem_ack = 1'b1;
    step("fetch_late_ack", IREQ | IRLD | PCINC | st(0));
    bus.imem_ack = 1'b0;
    step("late_decode", st(1));
    step("imm_bad_ex", st(2));
    step("imm_bad_fault", FLT | st(6));
    step("fault_hold", FLT | st(6));

    tick_rst();
    rst = 1'b0;
    for (int i = 0; i < 16; i++)
      step("fetch_to", IREQ | st(0));
    step("imem_timeout", FLT | st(6));
    bus.imem_ack = 1'b1;
    step("fault_sticky", FLT | st(6));
    bus.imem_ack = 1'b0;

    tick_rst();
    rst = 1'b0;
    fetch_dec(2'b01, 4'b0010);
    step("lwto_ex", afn(0) | BIMM | st(2));
    for (int i = 0; i < 16; i++)
      step("lwto_wait", DRE | st(3));
    step("dmem_timeout", FLT | st(6));

    tick_rst();
    rst = 1'b0;
    fetch_dec(2'b00, 4'b0010);
    step("pre_halt_ex", afn(2) | FWE | st(2));
    step("pre_halt_wb", REGWE | wbs(0) | st(4));
    fetch_dec(2'b11, 4'b1111);
    step("halt", HLT | st(5));
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    step("halt_hold", HLT | st(5));
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    step("halt_hold2", HLT | st(5));

    tick_rst();
    rst = 1'b0;
    fetch_dec(2'b11, 4'b0000);
    step("sys_bad", FLT | st(6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
